// File: rtl/myy_param_ctrl_if.sv
// Handshake/bus bundle between the instruction sequencer, the control unit and the datapath.
// Signals: sno, cop, x (towards control unit); sko, busy, err, y (from control unit).
interface myy_param_ctrl_if;
    logic        sno;
    logic [1:0]  cop;
    logic [3:0]  x;
    logic        sko;
    logic        busy;
    logic        err;
    logic [12:1] y;

    modport master (
        output sno, cop, x,
        input  sko, busy, err, y
    );

    modport slave (
        input  sno, cop, x,
        output sko, busy, err, y
    );
endinterface

// File: rtl/myy_param_ctrl.sv
// Mealy microprogram control unit: add/sub/Booth multiply/compare over an N-bit datapath.
// Ports: clk, set (async active-high reset), bus (slave: sno, cop, x in; sko, busy, err, y out).
// Optional overflow capture on add/sub is enabled by defining MYY_OVF_EN.
module myy_param_ctrl #(
    parameter int N = 4
) (
    input logic            clk,
    input logic            set,
    myy_param_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        SHIFT = 3'd2,
        NORM  = 3'd3,
        FLAGS = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       cop_r;
    logic [CNT_W-1:0] i;
    logic             last;
    logic [12:1]      y_c;
    logic             sko_c;

    assign last = (i == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            state <= IDLE;
            i     <= '0;
            cop_r <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sno) begin
                        cop_r <= bus.cop;
                        i     <= '0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (cop_r)
                        2'b11:   state <= IDLE;
                        2'b10:   state <= SHIFT;
                        default: state <= NORM;
                    endcase
                end
                SHIFT: begin
                    if (last) begin
                        state <= FLAGS;
                    end else begin
                        i     <= i + 1'b1;
                        state <= EXEC;
                    end
                end
                NORM:    state <= bus.x[2] ? FLAGS : IDLE;
                FLAGS:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MYY_OVF_EN
    logic err_r;

    // Sticky until the next accepted start; only add/sub can raise it.
    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            err_r <= 1'b0;
        end else if (state == IDLE && bus.sno) begin
            err_r <= 1'b0;
        end else if (state == EXEC && !cop_r[1] && bus.x[3]) begin
            err_r <= 1'b1;
        end
    end

    assign bus.err = err_r;
`else
    logic unused_x3;
    assign unused_x3 = bus.x[3];
    assign bus.err   = 1'b0;
`endif

    // Control vector is Mealy: it follows x within the current cycle.
    always_comb begin
        y_c   = '0;
        sko_c = 1'b0;
        if (!set) begin
            case (state)
                IDLE: begin
                    if (bus.sno) y_c = 12'h007;
                end
                EXEC: begin
                    case (cop_r)
                        2'b00: y_c = 12'h1C0;
                        2'b01: y_c = 12'h1E0;
                        2'b11: begin
                            y_c   = 12'h2E0;
                            sko_c = 1'b1;
                        end
                        default: begin
                            // Booth pair {RB[0], q(-1)}
                            case (bus.x[1:0])
                                2'b10:   y_c = 12'h120;
                                2'b01:   y_c = 12'h100;
                                default: y_c = 12'h000;
                            endcase
                        end
                    endcase
`ifdef MYY_OVF_EN
                    if (!cop_r[1] && bus.x[3]) y_c[11] = 1'b1;
`endif
                end
                SHIFT: y_c = 12'h018;
                NORM: begin
                    if (bus.x[2]) begin
                        y_c = 12'h004;
                    end else begin
                        y_c   = 12'h200;
                        sko_c = 1'b1;
                    end
                end
                FLAGS: begin
                    y_c   = 12'h200;
                    sko_c = 1'b1;
                end
                default: y_c = '0;
            endcase
        end
    end

    assign bus.y    = y_c;
    assign bus.sko  = sko_c;
    assign bus.busy = !set && (state != IDLE);

endmodule
